bf16_mult_sched: RTL

Round-robin scheduler that shares one registered bfloat16 multiplier (2-cycle latency) between NUM_REQ requesters, such as CNN PE lanes.
- Accepts at most one operand pair per cycle and drives the multiplier inputs.
- Tags each issue with its requester index and returns the product to that requester only.
- Supports a drain/quiesce handshake so the layer controller can wait for an empty pipeline.

---
 rtl/bf16_mult_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bf16_mult_sched.sv
// Round-robin scheduler sharing one registered bfloat16 multiplier between NUM_REQ requesters.
// Optional issue counter port issue_cnt is enabled by defining BF16_SCHED_CNT_EN.
module bf16_mult_sched #(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           mult_a,
  output logic [15:0]           mult_b,
  input  logic [15:0]           mult_out,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_data,
  input  logic                  drain,
  output logic                  idle
`ifdef BF16_SCHED_CNT_EN
  ,
  output logic [31:0]           issue_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = MULT_LAT + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr;
  logic [DEPTH-1:0] tag_vld;
  logic [IDX_W-1:0] tag_idx [DEPTH];
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             fire;

  // Cyclic scan upward from rr+1; the first valid requester wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cand      = '0;
    win_idx   = rr;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr) + 1 + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign req_ready = (state == RUN && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
  assign fire      = |(req_valid & req_ready);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      idle       <= 1'b0;
      rr         <= IDX_W'(NUM_REQ - 1);
      tag_vld    <= '0;
      mult_a     <= '0;
      mult_b     <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      if (fire) begin
        mult_a <= req_a[16*win_idx +: 16];
        mult_b <= req_b[16*win_idx +: 16];
        rr     <= win_idx;
      end

      tag_vld <= {tag_vld[DEPTH-2:0], fire};

      // The tail tag lines up with the product currently on mult_out.
      if (tag_vld[DEPTH-1]) begin
        resp_valid <= NUM_REQ'(1) << tag_idx[DEPTH-1];
        resp_data  <= mult_out;
      end else begin
        resp_valid <= '0;
      end

      case (state)
        RUN: begin
          if (drain) state <= DRAIN;
        end
        DRAIN: begin
          // An empty tag pipe also means resp_valid falls to 0 on this same edge.
          if (!(|tag_vld)) begin
            state <= DONE;
            idle  <= 1'b1;
          end
        end
        DONE: begin
          if (!drain) begin
            state <= RUN;
            idle  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          idle  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: index payload needs no reset; it is only consumed when its valid bit, which is reset, is set.
  always_ff @(posedge clk) begin
    tag_idx[0] <= win_idx;
    for (int i = 1; i < DEPTH; i++) tag_idx[i] <= tag_idx[i-1];
  end

`ifdef BF16_SCHED_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)       issue_cnt <= '0;
    else if (fire) issue_cnt <= issue_cnt + 32'd1;
  end
`endif

endmodule
